// File: rtl/pc_sequencer.sv
// Program-counter sequencer: sequential advance, prioritised redirects, stall with a one-entry redirect buffer.
// Optional PC history ring enabled by defining PC_TRACE_EN.
module pc_sequencer #(
    parameter int               WIDTH        = 32,
    parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
    parameter logic [WIDTH-1:0] EXC_VECTOR   = WIDTH'('h80),
    parameter int unsigned      INC          = 4,
    parameter int               TRACE_DEPTH  = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           stall_i,
    input  logic                           exc_i,
    input  logic                           jump_i,
    input  logic [WIDTH-1:0]               jump_target_i,
    input  logic                           branch_i,
    input  logic [WIDTH-1:0]               branch_target_i,
    output logic [WIDTH-1:0]               pc_o,
    output logic [WIDTH-1:0]               pc_next_o,
    output logic                           pending_o,
    input  logic [$clog2(TRACE_DEPTH)-1:0] trace_idx_i,
    output logic [WIDTH-1:0]               trace_data_o
);

    localparam int IDXW = $clog2(TRACE_DEPTH);

    typedef enum logic [1:0] {RUN, STALL, STALL_PEND} state_t;
    // Encoded so that a numerically larger class has higher priority.
    typedef enum logic [1:0] {CLS_NONE = 2'd0, CLS_BR = 2'd1, CLS_JMP = 2'd2, CLS_EXC = 2'd3} class_t;

    state_t           state_q, state_d;
    class_t           bufClass_q, bufClass_d;
    class_t           reqClass;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] bufTarget_q, bufTarget_d;
    logic [WIDTH-1:0] reqTarget;
    logic             pending_q;

    always_comb begin
        reqClass  = CLS_NONE;
        reqTarget = '0;
        if (exc_i) begin
            reqClass  = CLS_EXC;
            reqTarget = EXC_VECTOR;
        end else if (jump_i) begin
            reqClass  = CLS_JMP;
            reqTarget = jump_target_i;
        end else if (branch_i) begin
            reqClass  = CLS_BR;
            reqTarget = branch_target_i;
        end
    end

    always_comb begin
        pc_d        = pc_q;
        state_d     = state_q;
        bufClass_d  = bufClass_q;
        bufTarget_d = bufTarget_q;
        if (stall_i) begin
            // A stalled request only displaces the buffer when it is at least as urgent.
            if (reqClass != CLS_NONE && (state_q != STALL_PEND || reqClass >= bufClass_q)) begin
                state_d     = STALL_PEND;
                bufClass_d  = reqClass;
                bufTarget_d = reqTarget;
            end else if (state_q == RUN) begin
                state_d = STALL;
            end
        end else begin
            state_d    = RUN;
            bufClass_d = CLS_NONE;
            if (state_q == STALL_PEND) begin
                pc_d = exc_i ? EXC_VECTOR : bufTarget_q;
            end else if (reqClass != CLS_NONE) begin
                pc_d = reqTarget;
            end else begin
                pc_d = pc_q + WIDTH'(INC);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RUN;
            pc_q        <= RESET_VECTOR;
            bufClass_q  <= CLS_NONE;
            bufTarget_q <= '0;
            pending_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            bufClass_q  <= bufClass_d;
            bufTarget_q <= bufTarget_d;
            pending_q   <= (state_d == STALL_PEND);
        end
    end

    assign pc_o      = pc_q;
    assign pc_next_o = pc_d;
    assign pending_o = pending_q;

`ifdef PC_TRACE_EN
    logic [WIDTH-1:0] trace_q [TRACE_DEPTH];
    logic [IDXW-1:0]  wrPtr_q;
    logic [IDXW-1:0]  rdPtr;

    // The old PC is recorded only when the PC actually moves to a different value.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < TRACE_DEPTH; i++) begin
                trace_q[i] <= '0;
            end
            wrPtr_q <= '0;
        end else if (pc_d != pc_q) begin
            trace_q[wrPtr_q] <= pc_q;
            wrPtr_q          <= wrPtr_q + IDXW'(1);
        end
    end

    assign rdPtr        = wrPtr_q - trace_idx_i - IDXW'(1);
    assign trace_data_o = trace_q[rdPtr];
`else
    logic unusedTraceIdx;
    assign unusedTraceIdx = ^trace_idx_i;
    assign trace_data_o   = '0;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed scenarios then random traffic against a behavioural PC model.
// A second 8-bit instance covers narrow-width wrap-around.
module tb_pc_sequencer;

    localparam logic [31:0] EXC_V = 32'h80;
`ifdef PC_TRACE_EN
    localparam bit TRACE_ON = 1'b1;
`else
    localparam bit TRACE_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall = 1'b0;
    logic        exc = 1'b0;
    logic        jump = 1'b0;
    logic [31:0] jumpTarget = '0;
    logic        branch = 1'b0;
    logic [31:0] branchTarget = '0;
    logic [2:0]  traceIdx = '0;
    logic [31:0] pcOut;
    logic [31:0] pcNext;
    logic        pendingOut;
    logic [31:0] traceData;

    logic        rst8 = 1'b1;
    logic        exc8 = 1'b0;
    logic        jump8 = 1'b0;
    logic [7:0]  jumpTarget8 = '0;
    logic [7:0]  pc8;
    logic [7:0]  pcNext8;
    logic        pending8;
    logic [7:0]  traceData8;

    always #5 clk = ~clk;

    pc_sequencer dut (
        .clk(clk), .rst(rst), .stall_i(stall), .exc_i(exc),
        .jump_i(jump), .jump_target_i(jumpTarget),
        .branch_i(branch), .branch_target_i(branchTarget),
        .pc_o(pcOut), .pc_next_o(pcNext), .pending_o(pendingOut),
        .trace_idx_i(traceIdx), .trace_data_o(traceData)
    );

    pc_sequencer #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst8), .stall_i(1'b0), .exc_i(exc8),
        .jump_i(jump8), .jump_target_i(jumpTarget8),
        .branch_i(1'b0), .branch_target_i(8'h00),
        .pc_o(pc8), .pc_next_o(pcNext8), .pending_o(pending8),
        .trace_idx_i(3'd0), .trace_data_o(traceData8)
    );

    int checks = 0;
    int errors = 0;
    int stepNo = 0;

    // Reference model: PC, one buffered redirect (class 3=exc, 2=jump, 1=branch), and a history list, newest first.
    logic [31:0] mPc = '0;
    bit          mPend = 1'b0;
    int          mCls = 0;
    logic [31:0] mTgt = '0;
    logic [31:0] mTrace[$];

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL step%0d %s observed=%h expected=%h", stepNo, tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] expTrace(input int idx);
        if (!TRACE_ON) return 32'h0;
        if (idx < mTrace.size()) return mTrace[idx];
        return 32'h0;
    endfunction

    task automatic applyStimulus(input bit r, input bit st, input bit ex, input bit jp,
                                 input logic [31:0] jt, input bit br, input logic [31:0] bt);
        logic [31:0] nxt;
        logic [31:0] tgt;
        int          cls;
        int          idx;
        stepNo++;
        @(negedge clk);
        rst = r; stall = st; exc = ex; jump = jp; jumpTarget = jt; branch = br; branchTarget = bt;
        idx = $urandom_range(0, 7);
        traceIdx = idx[2:0];
        cls = ex ? 3 : jp ? 2 : br ? 1 : 0;
        tgt = ex ? EXC_V : jp ? jt : bt;
        if (st)              nxt = mPc;
        else if (ex)         nxt = EXC_V;
        else if (mPend)      nxt = mTgt;
        else if (cls > 0)    nxt = tgt;
        else                 nxt = mPc + 32'd4;
        #1;
        if (!r) checkOutput("pc_next", pcNext, nxt);
        @(posedge clk);
        #1;
        if (r) begin
            mPc = '0; mPend = 1'b0; mCls = 0; mTgt = '0;
            mTrace.delete();
        end else if (st) begin
            if (cls > 0 && (!mPend || cls >= mCls)) begin
                mPend = 1'b1; mCls = cls; mTgt = tgt;
            end
        end else begin
            if (nxt != mPc) begin
                mTrace.push_front(mPc);
                if (mTrace.size() > 8) void'(mTrace.pop_back());
            end
            mPc = nxt; mPend = 1'b0; mCls = 0;
        end
        checkOutput("pc", pcOut, mPc);
        checkOutput("pending", {31'b0, pendingOut}, {31'b0, mPend});
        checkOutput("trace", traceData, expTrace(idx));
    endtask

    // Holding a request-free stall keeps every observable value still while the index is swept.
    task automatic checkTraceAll();
        stepNo++;
        stall = 1'b1; exc = 1'b0; jump = 1'b0; branch = 1'b0;
        for (int i = 0; i < 8; i++) begin
            traceIdx = i[2:0];
            #1;
            checkOutput($sformatf("traceAll[%0d]", i), traceData, expTrace(i));
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 32'h0, 0, 32'h0);
    endtask

    initial begin
        bit          r, st, ex, jp, br;
        logic [31:0] jt, bt;

        applyStimulus(1, 0, 0, 0, 32'h0, 0, 32'h0);
        applyStimulus(1, 0, 0, 0, 32'h0, 0, 32'h0);
        checkTraceAll();

        idle(3);
        checkTraceAll();

        applyStimulus(0, 0, 0, 1, 32'h100, 1, 32'h200);

        applyStimulus(0, 1, 0, 0, 32'h0, 1, 32'h40);
        applyStimulus(0, 1, 0, 0, 32'h0, 0, 32'h0);
        applyStimulus(0, 1, 0, 0, 32'h0, 0, 32'h0);
        idle(1);

        applyStimulus(0, 1, 0, 0, 32'h0, 1, 32'h40);
        applyStimulus(0, 1, 0, 1, 32'h80, 0, 32'h0);
        applyStimulus(0, 0, 0, 0, 32'h0, 1, 32'hC0);

        applyStimulus(0, 1, 0, 1, 32'h300, 0, 32'h0);
        applyStimulus(0, 1, 0, 0, 32'h0, 1, 32'h400);
        idle(1);

        applyStimulus(0, 1, 0, 0, 32'h0, 1, 32'h500);
        applyStimulus(0, 1, 0, 0, 32'h0, 1, 32'h600);
        idle(1);

        applyStimulus(0, 1, 1, 0, 32'h0, 0, 32'h0);
        applyStimulus(0, 0, 0, 1, 32'h700, 0, 32'h0);

        applyStimulus(0, 1, 0, 0, 32'h0, 1, 32'h900);
        applyStimulus(0, 0, 1, 0, 32'h0, 0, 32'h0);

        applyStimulus(0, 0, 0, 1, 32'hFFFF_FFFC, 0, 32'h0);
        idle(2);

        applyStimulus(0, 1, 0, 0, 32'h0, 1, 32'h40);
        applyStimulus(1, 1, 0, 0, 32'h0, 1, 32'h60);
        checkTraceAll();
        idle(2);

        for (int n = 0; n < 400; n++) begin
            r  = ($urandom_range(0, 49) == 0);
            st = ($urandom_range(0, 9) < 4);
            ex = ($urandom_range(0, 19) == 0);
            jp = ($urandom_range(0, 6) == 0);
            br = ($urandom_range(0, 4) == 0);
            jt = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFF8 : $urandom;
            bt = $urandom;
            applyStimulus(r, st, ex, jp, jt, br, bt);
        end

        stepNo++;
        @(negedge clk);
        rst8 = 1'b1;
        @(posedge clk); #1;
        checkOutput("pc8_reset", 32'(pc8), 32'h00);
        checkOutput("pending8_reset", {31'b0, pending8}, 32'h0);
        checkOutput("trace8_reset", 32'(traceData8), 32'h00);
        @(negedge clk);
        rst8 = 1'b0; jump8 = 1'b1; jumpTarget8 = 8'hFC;
        @(posedge clk); #1;
        checkOutput("pc8_jump", 32'(pc8), 32'hFC);
        @(negedge clk);
        jump8 = 1'b0;
        #1;
        checkOutput("pc8_next_wrap", 32'(pcNext8), 32'h00);
        @(posedge clk); #1;
        checkOutput("pc8_wrap", 32'(pc8), 32'h00);
        @(negedge clk);
        exc8 = 1'b1;
        @(posedge clk); #1;
        checkOutput("pc8_exc", 32'(pc8), 32'h80);
        exc8 = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
